// File: rtl/router_dest_fifo_if.sv
// Handshake/data bundle between the router core, the destination FIFO and the destination reader.
// The FIFO uses the slave view; the driving side (core plus reader) uses the master view.
interface router_dest_fifo_if #(
    parameter int WIDTH = 8
) ();
    logic             write_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic             read_enb;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             full;
    logic             empty;
    logic             soft_reset;

    modport slave (
        input  write_enb, lfd_state, data_in, read_enb,
        output data_out, valid_out, full, empty, soft_reset
    );

    modport master (
        output write_enb, lfd_state, data_in, read_enb,
        input  data_out, valid_out, full, empty, soft_reset
    );
endinterface

// File: rtl/router_dest_fifo.sv
// Per-destination output FIFO of the router with header tagging and read-side packet tracking.
// Optional idle-timeout flush is enabled by defining ROUTER_DEST_FIFO_TIMEOUT_EN.
module router_dest_fifo #(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 30
) (
    input logic               clock,
    input logic               resetn,
    router_dest_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = WIDTH - 1;

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [AW:0]      wrPtr_q, wrPtr_d;
    logic [AW:0]      rdPtr_q, rdPtr_d;
    logic [WIDTH-1:0] dataOut_q, dataOut_d;
    logic [PW-1:0]    pktCnt_q, pktCnt_d;
    logic [WIDTH:0]   rdEntry;
    logic             fullFlag;
    logic             emptyFlag;
    logic             doWrite;
    logic             doRead;
    logic             flush;

    assign fullFlag  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
    assign emptyFlag = (wrPtr_q == rdPtr_q);
    assign doWrite   = bus.write_enb && !fullFlag;
    assign doRead    = bus.read_enb && !emptyFlag;
    assign rdEntry   = mem_q[rdPtr_q[AW-1:0]];

    assign bus.full      = fullFlag;
    assign bus.empty     = emptyFlag;
    assign bus.valid_out = !emptyFlag;
    assign bus.data_out  = dataOut_q;

`ifdef ROUTER_DEST_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] idleCnt_q, idleCnt_d;
    logic          softReset_q;
    logic          idle;

    assign idle           = !emptyFlag && !bus.read_enb;
    assign bus.soft_reset = softReset_q;

    always_comb begin
        idleCnt_d = '0;
        flush     = 1'b0;
        if (idle) begin
            if (idleCnt_q == TW'(TIMEOUT - 1)) begin
                flush = 1'b1;
            end else begin
                idleCnt_d = idleCnt_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            idleCnt_q   <= '0;
            softReset_q <= 1'b0;
        end else begin
            idleCnt_q   <= idleCnt_d;
            softReset_q <= flush;
        end
    end
`else
    assign flush          = 1'b0;
    assign bus.soft_reset = 1'b0;
`endif

    // A tagged entry always restarts the packet count, even mid-packet (truncation is silent).
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        dataOut_d = dataOut_q;
        pktCnt_d  = pktCnt_q;
        if (doWrite) begin
            wrPtr_d = wrPtr_q + (AW+1)'(1);
        end
        if (doRead) begin
            rdPtr_d   = rdPtr_q + (AW+1)'(1);
            dataOut_d = rdEntry[WIDTH-1:0];
            if (rdEntry[WIDTH]) begin
                pktCnt_d = PW'(rdEntry[WIDTH-1:2]) + PW'(1);
            end else if (pktCnt_q != '0) begin
                pktCnt_d = pktCnt_q - PW'(1);
            end
        end
        if (flush) begin
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            dataOut_d = '0;
            pktCnt_d  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            dataOut_q <= '0;
            pktCnt_q  <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            dataOut_q <= dataOut_d;
            pktCnt_q  <= pktCnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn && doWrite && !flush) begin
            mem_q[wrPtr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end
endmodule

// File: tb/tb_router_dest_fifo.sv
// Directed self-checking bench for router_dest_fifo; timeout checks follow ROUTER_DEST_FIFO_TIMEOUT_EN.
module tb_router_dest_fifo;
    logic clock = 1'b0;
    logic resetn;
    int   vectorCount = 0;
    int   missCount   = 0;

    router_dest_fifo_if #(.WIDTH(8)) bus ();

    router_dest_fifo #(
        .DEPTH  (16),
        .WIDTH  (8),
        .TIMEOUT(30)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic we, input logic lfd, input logic [7:0] din, input logic re);
        bus.write_enb = we;
        bus.lfd_state = lfd;
        bus.data_in   = din;
        bus.read_enb  = re;
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h55, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h55, 1'b0);
        checkOutput("rst_empty", 32'(bus.empty), 32'd1);
        checkOutput("rst_valid", 32'(bus.valid_out), 32'd0);
        checkOutput("rst_full", 32'(bus.full), 32'd0);
        checkOutput("rst_data", 32'(bus.data_out), 32'h0);
        checkOutput("rst_soft", 32'(bus.soft_reset), 32'd0);
        resetn = 1'b1;

        $display("[TB] packet pass-through");
        applyStimulus(1'b1, 1'b1, 8'h0D, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hA1, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hA2, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hA3, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h0F, 1'b0);
        checkOutput("pkt_valid", 32'(bus.valid_out), 32'd1);
        begin
            logic [7:0] expData [5] = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h0F};
            logic [6:0] expCnt  [5] = '{7'd4, 7'd3, 7'd2, 7'd1, 7'd0};
            for (int i = 0; i < 5; i++) begin
                applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
                checkOutput("pkt_data", 32'(bus.data_out), 32'(expData[i]));
                checkOutput("pkt_cnt", 32'(dut.pktCnt_q), 32'(expCnt[i]));
            end
        end
        checkOutput("pkt_empty", 32'(bus.empty), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("rd_empty_hold", 32'(bus.data_out), 32'h0F);

        $display("[TB] full and wrap");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        end
        checkOutput("full_set", 32'(bus.full), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'hEE, 1'b0);
        checkOutput("full_hold", 32'(bus.full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("full_order", 32'(bus.data_out), 32'(8'h10 + i));
        end
        checkOutput("full_drained", 32'(bus.empty), 32'd1);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("wrap_data", 32'(bus.data_out), 32'(8'h40 + i));
        end
        checkOutput("wrap_empty", 32'(bus.empty), 32'd1);

        $display("[TB] simultaneous read and write");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'h90 + i), 1'b1);
            checkOutput("rw_data", 32'(bus.data_out), 32'(8'h80 + i));
            checkOutput("rw_full", 32'(bus.full), 32'd0);
            checkOutput("rw_empty", 32'(bus.empty), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("rw_drain", 32'(bus.data_out), 32'(i < 4 ? 8'h84 + i : 8'h90 + i - 4));
        end
        checkOutput("rw_count8", 32'(bus.empty), 32'd1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 8'hFF, 1'b1);
        checkOutput("fullrw_data", 32'(bus.data_out), 32'hA0);
        checkOutput("fullrw_full", 32'(bus.full), 32'd0);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("fullrw_drain", 32'(bus.data_out), 32'(8'hA0 + i));
        end
        checkOutput("fullrw_count15", 32'(bus.empty), 32'd1);

        $display("[TB] reset mid-packet");
        applyStimulus(1'b1, 1'b1, 8'h15, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hB1, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hB2, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hB3, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("mid_hdr_cnt", 32'(dut.pktCnt_q), 32'd6);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("mid_cnt", 32'(dut.pktCnt_q), 32'd4);
        resetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        resetn = 1'b1;
        checkOutput("mid_rst_empty", 32'(bus.empty), 32'd1);
        checkOutput("mid_rst_cnt", 32'(dut.pktCnt_q), 32'd0);
        checkOutput("mid_rst_data", 32'(bus.data_out), 32'h0);
        applyStimulus(1'b1, 1'b1, 8'h08, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("mid_new_data", 32'(bus.data_out), 32'h08);
        checkOutput("mid_new_cnt", 32'(dut.pktCnt_q), 32'd3);

        $display("[TB] idle timeout");
        applyStimulus(1'b1, 1'b0, 8'h77, 1'b0);
`ifdef ROUTER_DEST_FIFO_TIMEOUT_EN
        for (int k = 1; k <= 31; k++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
            checkOutput("to_soft", 32'(bus.soft_reset), 32'(k == 30));
            if (k == 30) begin
                checkOutput("to_empty", 32'(bus.empty), 32'd1);
                checkOutput("to_data", 32'(bus.data_out), 32'h0);
            end
        end
        applyStimulus(1'b1, 1'b0, 8'h61, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h62, 1'b0);
        for (int k = 1; k < 20; k++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
            checkOutput("to2_soft_pre", 32'(bus.soft_reset), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("to2_read", 32'(bus.data_out), 32'h61);
        for (int j = 1; j <= 30; j++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
            checkOutput("to2_soft", 32'(bus.soft_reset), 32'(j == 30));
        end
        checkOutput("to2_empty", 32'(bus.empty), 32'd1);
`else
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
            checkOutput("hold_soft", 32'(bus.soft_reset), 32'd0);
        end
        checkOutput("hold_valid", 32'(bus.valid_out), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("hold_data", 32'(bus.data_out), 32'h77);
        checkOutput("hold_empty", 32'(bus.empty), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
